// File: rtl/riscv_v_skid_stage.sv
// Two-entry skid buffer stage: main entry drives the outputs, skid entry absorbs a beat accepted under stall.
// Optional back-pressure counter enabled by defining RISCV_V_SKID_STALL_CNT_EN.
module riscv_v_skid_stage #(
   parameter int DATA_WIDTH      = 32,
   parameter bit FLUSH_KEEP_DATA = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic [1:0]            occupancy,
   output logic [31:0]           stall_cnt
);

   // state | meaning
   // EMPTY | no entries held
   // ONE   | main entry valid
   // FULL  | main and skid entries valid
   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;

   logic [1:0]            state_q, state_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] main_q, main_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic                  xfer_in, xfer_out;

   assign xfer_in  = in_valid && in_ready_q;
   assign xfer_out = out_valid_q && out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_EMPTY: if (xfer_in) state_d = S_ONE;
         S_ONE: begin
            if (xfer_in && !xfer_out)      state_d = S_FULL;
            else if (!xfer_in && xfer_out) state_d = S_EMPTY;
         end
         S_FULL:  if (xfer_out) state_d = S_ONE;
         default: state_d = S_EMPTY;
      endcase
      if (flush) state_d = S_EMPTY;
   end

   // Handshake flags are registered copies of the next-state decode, so
   // in_ready never sees out_ready through logic.
   always_comb begin
      in_ready_d  = (state_d != S_FULL);
      out_valid_d = (state_d != S_EMPTY);
   end

   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      if (flush) begin
         if (!FLUSH_KEEP_DATA) begin
            main_d = '0;
            skid_d = '0;
         end
      end else begin
         case (state_q)
            S_EMPTY: if (xfer_in) main_d = in_data;
            S_ONE: begin
               if (xfer_in && xfer_out) main_d = in_data;
               else if (xfer_in)        skid_d = in_data;
            end
            S_FULL:  if (xfer_out) main_d = skid_q;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign occupancy = state_q;

`ifdef RISCV_V_SKID_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
      end else if (flush) begin
         stall_q <= '0;
      end else if (out_valid_q && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule
